// File: rtl/watchdog_reset.sv
// watchdog_reset: re-asserts reset at run time (PULSE_LEN-cycle wdt_rst) when kicks stop.
// Optional macro WDT_WINDOW_EN: a kick in ARMED before cnt reaches WIN_MIN is a fault and bites.
//
// state | meaning
// IDLE  | disarmed, cnt held at 0
// ARMED | counting since arm/last kick, below WARN_AT
// WARN  | count past WARN_AT, warn high, bite pending
// BITE  | wdt_rst high for PULSE_LEN cycles, inputs ignored
// HOLD  | HOLDOFF cycles of quiet before re-arming or going idle
module watchdog_reset #(
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 4000,
  parameter int WARN_AT   = 3000,
  parameter int PULSE_LEN = 62,
  parameter int HOLDOFF   = 62,
  parameter int WIN_MIN   = 500
) (
  input  logic       clk40,
  input  logic       rst,
  input  logic       arm,
  input  logic       kick,
  output logic       wdt_rst,
  output logic       warn,
  output logic [7:0] bite_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    WARN  = 3'd2,
    BITE  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] WARN_TC    = CNT_W'(WARN_AT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PULSE_TC   = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(HOLDOFF - 1);

  if (WARN_AT < 1 || WARN_AT >= TIMEOUT || PULSE_LEN < 1 || HOLDOFF < 1 ||
      TIMEOUT >= (1 << CNT_W) || WIN_MIN >= (1 << CNT_W)) begin : g_bad_params
    $error("watchdog_reset: inconsistent timing parameters");
  end

`ifdef WDT_WINDOW_EN
  localparam logic [CNT_W-1:0] WIN_LIM = CNT_W'(WIN_MIN);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign state_o = state;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk40) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wdt_rst  <= 1'b0;
      warn     <= 1'b0;
      bite_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (arm) state <= ARMED;
        end

        ARMED: begin
          if (!arm) begin
            state <= IDLE;
            cnt   <= '0;
          end
`ifdef WDT_WINDOW_EN
          else if (kick && cnt < WIN_LIM) begin
            state    <= BITE;
            cnt      <= '0;
            wdt_rst  <= 1'b1;
            bite_cnt <= sat_inc(bite_cnt);
          end
`endif
          else if (kick) begin
            cnt <= '0;
          end else if (cnt == WARN_TC) begin
            state <= WARN;
            warn  <= 1'b1;
            cnt   <= cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WARN: begin
          if (!arm) begin
            state <= IDLE;
            warn  <= 1'b0;
            cnt   <= '0;
          end else if (kick) begin
            state <= ARMED;
            warn  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_TC) begin
            state    <= BITE;
            warn     <= 1'b0;
            wdt_rst  <= 1'b1;
            cnt      <= '0;
            bite_cnt <= sat_inc(bite_cnt);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BITE: begin
          if (cnt == PULSE_TC) begin
            state   <= HOLD;
            wdt_rst <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          // arm is only looked at here, so a disarm during the bite lands at the end of HOLD
          if (cnt == HOLD_TC) begin
            state <= arm ? ARMED : IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          wdt_rst <= 1'b0;
          warn    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_watchdog_reset.sv
// Scoreboarded bench for watchdog_reset: a timeline model predicts outputs per cycle,
// a monitor pops predictions after each clk40 edge and compares.
module tb_watchdog_reset;
  localparam int CNT_W     = 16;
  localparam int TIMEOUT   = 4000;
  localparam int WARN_AT   = 3000;
  localparam int PULSE_LEN = 62;
  localparam int HOLDOFF   = 62;
  localparam int WIN_MIN   = 500;
`ifdef WDT_WINDOW_EN
  localparam bit WINDOWED = 1'b1;
`else
  localparam bit WINDOWED = 1'b0;
`endif

  logic       clk40 = 1'b0;
  logic       rst   = 1'b1;
  logic       arm   = 1'b0;
  logic       kick  = 1'b0;
  logic       wdt_rst;
  logic       warn;
  logic [7:0] bite_cnt;
  logic [2:0] state_o;

  always #5 clk40 = ~clk40;

  watchdog_reset #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .WARN_AT(WARN_AT),
    .PULSE_LEN(PULSE_LEN), .HOLDOFF(HOLDOFF), .WIN_MIN(WIN_MIN)
  ) dut (
    .clk40(clk40), .rst(rst), .arm(arm), .kick(kick),
    .wdt_rst(wdt_rst), .warn(warn), .bite_cnt(bite_cnt), .state_o(state_o)
  );

  typedef struct packed {
    logic       rst_req;
    logic       warn;
    logic [7:0] bites;
    logic [2:0] st;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // Timeline model: m_age = cycles since arming/last accepted kick,
  // m_seq = position in the combined pulse+holdoff sequence (-1 when none).
  bit m_active = 1'b0;
  int m_age    = 0;
  int m_seq    = -1;
  int m_bites  = 0;

  task automatic start_bite();
    m_seq   = 0;
    m_bites = (m_bites < 255) ? m_bites + 1 : 255;
  endtask

  task automatic model_step(input bit r, input bit a, input bit k, output exp_t e);
    if (r) begin
      m_active = 1'b0;
      m_age    = 0;
      m_seq    = -1;
      m_bites  = 0;
    end else if (m_seq >= 0) begin
      m_seq++;
      if (m_seq == PULSE_LEN + HOLDOFF) begin
        m_seq    = -1;
        m_active = a;
        m_age    = 0;
      end
    end else if (!m_active) begin
      m_active = a;
      m_age    = 0;
    end else if (!a) begin
      m_active = 1'b0;
      m_age    = 0;
    end else if (k && WINDOWED && m_age < WIN_MIN) begin
      start_bite();
    end else if (k) begin
      m_age = 0;
    end else begin
      m_age++;
      if (m_age == TIMEOUT) start_bite();
    end
    e.rst_req = (m_seq >= 0) && (m_seq < PULSE_LEN);
    e.warn    = (m_seq < 0) && m_active && (m_age >= WARN_AT);
    e.bites   = 8'(m_bites);
    if (m_seq >= 0)          e.st = (m_seq < PULSE_LEN) ? 3'd3 : 3'd4;
    else if (!m_active)      e.st = 3'd0;
    else if (m_age >= WARN_AT) e.st = 3'd2;
    else                     e.st = 3'd1;
  endtask

  task automatic cyc(input bit r, input bit a, input bit k);
    exp_t e;
    @(negedge clk40);
    rst  = r;
    arm  = a;
    kick = k;
    model_step(r, a, k, e);
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk40);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wdt_rst",  {7'd0, wdt_rst}, {7'd0, e.rst_req});
        chk("warn",     {7'd0, warn},    {7'd0, e.warn});
        chk("bite_cnt", bite_cnt,        e.bites);
        chk("state_o",  {5'd0, state_o}, {5'd0, e.st});
      end
    end
  end

  initial begin : stimulus
    bit a;
    // reset, then a long disarmed stretch with stray kicks
    repeat (3) cyc(1, 0, 0);
    for (int i = 0; i < 10000; i++) cyc(0, 0, ($urandom_range(0, 99) == 0));

    // armed and kicked regularly, never inside the early window
    for (int i = 0; i < 20000; i++) cyc(0, 1, (i % $urandom_range(600, 1000)) == 999 || (i % 1000) == 999);

    // starved: two full bite sequences
    for (int i = 0; i < 8500; i++) cyc(0, 1, 0);

    // rescue kick at count 3500 while warning
    for (int i = 0; i < 10000 && !(m_seq < 0 && m_active && m_age == 3500); i++) cyc(0, 1, 0);
    cyc(0, 1, 1);
    for (int i = 0; i < 3500; i++) cyc(0, 1, 0);

    // reset in the 10th cycle of a pulse; kicks during BITE/HOLD are ignored
    for (int i = 0; i < 10000 && m_seq != 9; i++) cyc(0, 1, (m_seq >= 0) && ($urandom_range(0, 1) == 1));
    cyc(1, 1, 0);
    for (int i = 0; i < 4300; i++) cyc(0, 1, (m_seq >= 0) && ($urandom_range(0, 1) == 1));

    // early kick at 100, then a kick at 600
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 10000 && !(m_seq < 0 && m_active && m_age == 100); i++) cyc(0, 1, 0);
    cyc(0, 1, 1);
    for (int i = 0; i < 10000 && !(m_seq < 0 && m_active && m_age == 600); i++) cyc(0, 1, 0);
    cyc(0, 1, 1);
    for (int i = 0; i < 200; i++) cyc(0, 1, 0);

    // random soak: sparse kicks, occasional disarm and reset
    a = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 799) == 0) a = ~a;
      cyc(($urandom_range(0, 2999) == 0), a, ($urandom_range(0, 1499) == 0));
    end
    cyc(0, 0, 1);

    repeat (3) @(posedge clk40);
    #5;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
